// File: rtl/player_pkg.sv
// Shared constants and types for the maze player controller: grid geometry,
// direction/state encodings, and the teleport pair table.
package player_pkg;

    localparam int TILE_W    = 32;
    localparam int TILE_H    = 30;
    localparam int GRID_COLS = 20;
    localparam int GRID_ROWS = 16;
    localparam int COL_W     = 5;
    localparam int ROW_W     = 4;
    localparam int PX_W      = 10;
    localparam int PY_W      = 9;
    localparam int NUM_TELE  = 5;

    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_e;
    typedef enum logic [1:0] {IDLE, PROBE, TELE, WIN} state_e;

    typedef struct packed {
        logic [COL_W-1:0] col;
        logic [ROW_W-1:0] row;
    } tile_t;

    localparam tile_t START_TILE  = '{col: 5'd0,  row: 4'd0};
    localparam tile_t FINISH_TILE = '{col: 5'd17, row: 4'd13};

    // Pair i links TELE_A[i] and TELE_B[i]: pink, green, cyan, purple, grey.
    localparam tile_t TELE_A [NUM_TELE] = '{
        '{col: 5'd7,  row: 4'd5},
        '{col: 5'd13, row: 4'd3},
        '{col: 5'd0,  row: 4'd15},
        '{col: 5'd9,  row: 4'd8},
        '{col: 5'd17, row: 4'd12}
    };
    localparam tile_t TELE_B [NUM_TELE] = '{
        '{col: 5'd13, row: 4'd1},
        '{col: 5'd1,  row: 4'd8},
        '{col: 5'd8,  row: 4'd8},
        '{col: 5'd11, row: 4'd14},
        '{col: 5'd17, row: 4'd14}
    };

    // A tile that is not a teleport endpoint maps to itself.
    function automatic tile_t tele_partner(input tile_t t);
        tile_t p;
        p = t;
        for (int i = 0; i < NUM_TELE; i++) begin
            if (t == TELE_A[i])
                p = TELE_B[i];
            else if (t == TELE_B[i])
                p = TELE_A[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/player_tile_center.sv
// Converts a (col,row) tile coordinate into the pixel at the centre of that tile.
module tile_center
    import player_pkg::*;
(
    input  logic [COL_W-1:0] col,
    input  logic [ROW_W-1:0] row,
    output logic [PX_W-1:0]  px,
    output logic [PY_W-1:0]  py
);

    assign px = PX_W'(col) * PX_W'(TILE_W) + PX_W'(TILE_W / 2);
    assign py = PY_W'(row) * PY_W'(TILE_H) + PY_W'(TILE_H / 2);

endmodule

// File: rtl/player_ctrl.sv
// Tile-based player movement controller: probes the map at the target tile,
// then resolves walls, lava, finish and teleports.
module player_ctrl
    import player_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             move_valid,
    input  logic [1:0]       move_dir,
    output logic             move_ready,
    input  logic             restart,
    input  logic             walls,
    input  logic             lava_pits,
    input  logic             teleport_pink,
    input  logic             teleport_green,
    input  logic             teleport_cyan,
    input  logic             teleport_purple,
    input  logic             teleport_grey,
    input  logic             finish_line,
    output logic [PX_W-1:0]  probe_x,
    output logic [PY_W-1:0]  probe_y,
    output logic [COL_W-1:0] tile_col,
    output logic [ROW_W-1:0] tile_row,
    output logic [PX_W-1:0]  pos_x,
    output logic [PY_W-1:0]  pos_y,
    output logic             move_done,
    output logic             bumped,
    output logic             died,
    output logic             teleported,
    output logic             won,
    output logic [7:0]       deaths
);

    state_e state;
    tile_t  tile, tgt, nxt, probe_tile;
    logic   off_grid, tele_any;

    assign tele_any = teleport_pink | teleport_green | teleport_cyan |
                      teleport_purple | teleport_grey;

    always_comb begin
        nxt      = tile;
        off_grid = 1'b0;
        case (dir_e'(move_dir))
            DIR_UP: begin
                if (tile.row == '0) off_grid = 1'b1;
                else                nxt.row  = tile.row - 4'd1;
            end
            DIR_DOWN: begin
                if (tile.row == ROW_W'(GRID_ROWS - 1)) off_grid = 1'b1;
                else                                   nxt.row  = tile.row + 4'd1;
            end
            DIR_LEFT: begin
                if (tile.col == '0) off_grid = 1'b1;
                else                nxt.col  = tile.col - 5'd1;
            end
            DIR_RIGHT: begin
                if (tile.col == COL_W'(GRID_COLS - 1)) off_grid = 1'b1;
                else                                   nxt.col  = tile.col + 5'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            tile       <= START_TILE;
            tgt        <= START_TILE;
            won        <= 1'b0;
            deaths     <= 8'd0;
            move_done  <= 1'b0;
            bumped     <= 1'b0;
            died       <= 1'b0;
            teleported <= 1'b0;
        end else begin
            move_done  <= 1'b0;
            bumped     <= 1'b0;
            died       <= 1'b0;
            teleported <= 1'b0;
            case (state)
                IDLE: begin
                    if (move_valid) begin
                        if (off_grid) begin
                            move_done <= 1'b1;
                            bumped    <= 1'b1;
                        end else begin
                            tgt   <= nxt;
                            state <= PROBE;
                        end
                    end
                end
                PROBE: begin
                    if (walls) begin
                        bumped    <= 1'b1;
                        move_done <= 1'b1;
                        state     <= IDLE;
                    end else if (lava_pits) begin
                        tile      <= START_TILE;
                        if (deaths != 8'hFF) deaths <= deaths + 8'd1;
                        died      <= 1'b1;
                        move_done <= 1'b1;
                        state     <= IDLE;
                    end else if (finish_line) begin
                        tile      <= tgt;
                        won       <= 1'b1;
                        move_done <= 1'b1;
                        state     <= WIN;
                    end else if (tele_any) begin
                        tile  <= tgt;
                        state <= TELE;
                    end else begin
                        tile      <= tgt;
                        move_done <= 1'b1;
                        state     <= IDLE;
                    end
                end
                // The arrival tile is taken as-is; it is never probed again.
                TELE: begin
                    tile       <= tele_partner(tile);
                    teleported <= 1'b1;
                    move_done  <= 1'b1;
                    state      <= IDLE;
                end
                WIN: begin
                    if (restart) begin
                        tile   <= START_TILE;
                        won    <= 1'b0;
                        deaths <= 8'd0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign move_ready = (state == IDLE);
    assign tile_col   = tile.col;
    assign tile_row   = tile.row;
    assign probe_tile = (state == PROBE) ? tgt : tile;

    tile_center u_probe_center (
        .col (probe_tile.col),
        .row (probe_tile.row),
        .px  (probe_x),
        .py  (probe_y)
    );

    tile_center u_pos_center (
        .col (tile.col),
        .row (tile.row),
        .px  (pos_x),
        .py  (pos_y)
    );

endmodule

// File: tb/tb_player_ctrl.sv
// Scoreboard bench for player_ctrl: a behavioural maze model predicts each
// move's outcome; a monitor checks it when move_done fires.
module tb_player_ctrl;

    logic       clk = 1'b0;
    logic       reset, move_valid, restart;
    logic [1:0] move_dir;
    logic       move_ready;
    logic       walls, lava_pits, finish_line;
    logic       teleport_pink, teleport_green, teleport_cyan, teleport_purple, teleport_grey;
    logic [9:0] probe_x, pos_x;
    logic [8:0] probe_y, pos_y;
    logic [4:0] tile_col;
    logic [3:0] tile_row;
    logic       move_done, bumped, died, teleported, won;
    logic [7:0] deaths;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    player_ctrl dut (
        .clk(clk), .reset(reset), .move_valid(move_valid), .move_dir(move_dir),
        .move_ready(move_ready), .restart(restart),
        .walls(walls), .lava_pits(lava_pits),
        .teleport_pink(teleport_pink), .teleport_green(teleport_green),
        .teleport_cyan(teleport_cyan), .teleport_purple(teleport_purple),
        .teleport_grey(teleport_grey), .finish_line(finish_line),
        .probe_x(probe_x), .probe_y(probe_y), .tile_col(tile_col), .tile_row(tile_row),
        .pos_x(pos_x), .pos_y(pos_y), .move_done(move_done), .bumped(bumped),
        .died(died), .teleported(teleported), .won(won), .deaths(deaths)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Maze: 0 floor, 1 wall, 2 lava, 3 finish, 4..8 teleport colour index+4.
    int ta_c [5] = '{7, 13, 0, 9, 17};
    int ta_r [5] = '{5, 3, 15, 8, 12};
    int tb_c [5] = '{13, 1, 8, 11, 17};
    int tb_r [5] = '{1, 8, 8, 14, 14};

    function automatic int kind(input int c, input int r);
        if (c == 1 && r == 0) return 1;
        if (c == 5 && r >= 2 && r <= 6) return 1;
        if (r == 10 && c >= 3 && c <= 8) return 1;
        if ((c == 0 && r == 7) || (c == 4 && r == 4) || (c == 10 && r == 10) || (c == 15 && r == 2))
            return 2;
        if (c == 17 && r == 13) return 3;
        for (int i = 0; i < 5; i++)
            if ((c == ta_c[i] && r == ta_r[i]) || (c == tb_c[i] && r == tb_r[i])) return 4 + i;
        return 0;
    endfunction

    int map_k;
    assign map_k           = kind(int'(probe_x) / 32, int'(probe_y) / 30);
    assign walls           = (map_k == 1);
    assign lava_pits       = (map_k == 2);
    assign finish_line     = (map_k == 3);
    assign teleport_pink   = (map_k == 4);
    assign teleport_green  = (map_k == 5);
    assign teleport_cyan   = (map_k == 6);
    assign teleport_purple = (map_k == 7);
    assign teleport_grey   = (map_k == 8);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int acc; int lat; int col; int row;
        bit bump; bit died; bit tele; int deaths; bit won;
    } exp_t;
    exp_t q[$];
    exp_t me;

    int  m_col, m_row, m_deaths;
    bit  m_won;

    always @(negedge clk) begin
        if (!reset) begin
            if ((bumped || died || teleported) && !move_done) chk("stray_pulse", 1, 0);
            if (move_done) begin
                if (q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    me = q.pop_front();
                    chk("latency", cyc - me.acc, me.lat);
                    chk("tile_col", int'(tile_col), me.col);
                    chk("tile_row", int'(tile_row), me.row);
                    chk("pos_x", int'(pos_x), me.col * 32 + 16);
                    chk("pos_y", int'(pos_y), me.row * 30 + 15);
                    chk("bumped", int'(bumped), int'(me.bump));
                    chk("died", int'(died), int'(me.died));
                    chk("teleported", int'(teleported), int'(me.tele));
                    chk("deaths", int'(deaths), me.deaths);
                    chk("won", int'(won), int'(me.won));
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (move_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (move_ready !== 1'b1) chk("ready_timeout", 0, 1);
    endtask

    task automatic do_move(input int dir);
        exp_t e;
        int tc, tr, k, oc, orow, i;
        bit off;
        wait_ready();
        if (move_ready !== 1'b1) return;
        oc = m_col; orow = m_row;
        tc = m_col; tr = m_row;
        case (dir)
            0: tr--;
            1: tr++;
            2: tc--;
            default: tc++;
        endcase
        off = (tc < 0 || tc > 19 || tr < 0 || tr > 15);
        k = off ? 0 : kind(tc, tr);
        e.acc = cyc; e.lat = 2; e.col = m_col; e.row = m_row;
        e.bump = 0; e.died = 0; e.tele = 0;
        if (off) begin
            e.lat = 1; e.bump = 1;
        end else if (k == 1) begin
            e.bump = 1;
        end else if (k == 2) begin
            e.col = 0; e.row = 0; e.died = 1;
            if (m_deaths < 255) m_deaths++;
        end else if (k == 3) begin
            e.col = tc; e.row = tr; m_won = 1;
        end else if (k >= 4) begin
            i = k - 4;
            e.lat = 3; e.tele = 1;
            if (tc == ta_c[i] && tr == ta_r[i]) begin e.col = tb_c[i]; e.row = tb_r[i]; end
            else begin e.col = ta_c[i]; e.row = ta_r[i]; end
        end else begin
            e.col = tc; e.row = tr;
        end
        e.deaths = m_deaths; e.won = m_won;
        m_col = e.col; m_row = e.row;
        move_valid = 1'b1;
        move_dir   = 2'(dir);
        q.push_back(e);
        @(negedge clk);
        move_valid = 1'b0;
        if (off) begin
            chk("probe_x_offgrid", int'(probe_x), oc * 32 + 16);
            chk("probe_y_offgrid", int'(probe_y), orow * 30 + 15);
        end else begin
            chk("probe_x", int'(probe_x), tc * 32 + 16);
            chk("probe_y", int'(probe_y), tr * 30 + 15);
        end
        if (!off && k >= 4) begin
            @(negedge clk);
            chk("tele_mid_col", int'(tile_col), tc);
            chk("tele_mid_row", int'(tile_row), tr);
        end
    endtask

    task automatic chk_start_state(input int exp_deaths);
        chk("rst_tile_col", int'(tile_col), 0);
        chk("rst_tile_row", int'(tile_row), 0);
        chk("rst_pos_x", int'(pos_x), 16);
        chk("rst_pos_y", int'(pos_y), 15);
        chk("rst_probe_x", int'(probe_x), 16);
        chk("rst_probe_y", int'(probe_y), 15);
        chk("rst_ready", int'(move_ready), 1);
        chk("rst_won", int'(won), 0);
        chk("rst_deaths", int'(deaths), exp_deaths);
        chk("rst_pulses", int'({move_done, bumped, died, teleported}), 0);
    endtask

    task automatic do_restart();
        repeat (2) @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        m_col = 0; m_row = 0; m_deaths = 0; m_won = 0;
        chk_start_state(0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; move_valid = 1'b0; restart = 1'b0; move_dir = 2'd0;
        m_col = 0; m_row = 0; m_deaths = 0; m_won = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_start_state(0);

        do_move(0);                    // off-grid up
        do_move(2);                    // off-grid left
        do_move(3);                    // wall at (1,0)
        do_move(1);                    // floor (0,1)
        repeat (6) do_move(1);         // lava at (0,7)
        for (int i = 0; i < 255; i++) repeat (7) do_move(1);
        repeat (4) @(negedge clk);
        chk("deaths_saturated", int'(deaths), 255);

        restart = 1'b1;                // ignored outside WIN
        @(negedge clk);
        restart = 1'b0;
        @(negedge clk);
        chk("restart_idle_deaths", int'(deaths), 255);
        chk("restart_idle_ready", int'(move_ready), 1);

        do_move(1);
        repeat (7) do_move(3);
        repeat (3) do_move(1);         // now at (7,4)
        do_move(1);                    // pink (7,5) -> (13,1)
        repeat (5) do_move(3);
        repeat (12) do_move(1);
        do_move(2);                    // finish (17,13)
        repeat (2) @(negedge clk);
        chk("won_level", int'(won), 1);
        for (int i = 0; i < 3; i++) begin
            move_valid = 1'b1;
            move_dir   = 2'($urandom_range(0, 3));
            chk("win_ready", int'(move_ready), 0);
            @(negedge clk);
        end
        move_valid = 1'b0;
        chk("win_tile_col", int'(tile_col), 17);
        chk("win_tile_row", int'(tile_row), 13);
        do_restart();

        for (int i = 0; i < 400; i++) begin
            if (m_won) do_restart();
            else do_move(int'($urandom_range(0, 3)));
        end
        if (m_won) do_restart();

        // Reset while the target is being probed.
        wait_ready();
        move_valid = 1'b1;
        move_dir   = (m_row < 15) ? 2'd1 : 2'd0;
        @(negedge clk);
        move_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_col = 0; m_row = 0; m_deaths = 0; m_won = 0;
        chk_start_state(0);
        do_move(1);

        repeat (6) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/player_ctrl.md
PLAYER_CTRL -- requirements
Module: player_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  single system clock; all logic on its rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: move_valid  in  1  move request present.
REQ-004 SHALL have port: move_dir  in  2  requested direction: 0 up, 1 down, 2 left, 3 right.
REQ-005 SHALL have port: move_ready  out  1  controller can accept a move.
REQ-006 SHALL have port: restart  in  1  return to start after a win.
REQ-007 SHALL have ports: walls, lava_pits, teleport_pink, teleport_green, teleport_cyan, teleport_purple, teleport_grey, finish_line  in  1 each  map flags for the current probe pixel, combinational from the map block.
REQ-008 SHALL have ports: probe_x  out  10, probe_y  out  9  registered pixel address driven to the map block.
REQ-009 SHALL have ports: tile_col  out  5, tile_row  out  4  current player tile.
REQ-010 SHALL have ports: pos_x  out  10, pos_y  out  9  centre pixel of the current tile, for drawing.
REQ-011 SHALL have ports: move_done, bumped, died, teleported  out  1 each  single-cycle result pulses.
REQ-012 SHALL have ports: won  out  1 (level), deaths  out  8 (death count).

Function
REQ-013 Grid SHALL be 20 cols x 16 rows of 32x30-pixel tiles; tile centre = (col*32+16, row*30+15).
REQ-014 FSM states SHALL be IDLE, PROBE, TELE, WIN.
REQ-015 move_ready SHALL be 1 only in IDLE; a move is accepted on a cycle with move_valid && move_ready.
REQ-016 On acceptance (cycle A), if the target tile is off-grid, the controller SHALL stay in IDLE, leave the position unchanged, and pulse bumped and move_done in A+1 without probing.
REQ-017 Otherwise probe_x/probe_y SHALL equal the target tile centre in A+1, with the state PROBE.
REQ-018 In PROBE, flags SHALL resolve in priority order: walls > lava_pits > finish_line > any teleport > plain floor.
REQ-019 Wall: position SHALL be unchanged; pulse bumped; return to IDLE.
REQ-020 Lava: position SHALL become (0,0); deaths SHALL increment, saturating at 255; pulse died; return to IDLE.
REQ-021 Finish: position SHALL become the target; won SHALL be set; go to WIN.
REQ-022 Teleport: position SHALL become the target; go to TELE. In TELE, position SHALL become the partner tile from the package table, with teleported pulsed; return to IDLE. The partner tile SHALL NOT be re-evaluated.
REQ-023 Plain floor: position SHALL become the target; return to IDLE.
REQ-024 move_done SHALL pulse in A+2 for non-teleport outcomes and in A+3 for teleport. The bumped, died and teleported pulses SHALL coincide with move_done. move_ready SHALL return in the same cycle.
REQ-025 Teleport pairs (col,row): pink (7,5)<->(13,1); green (13,3)<->(1,8); cyan (0,15)<->(8,8); purple (9,8)<->(11,14); grey (17,12)<->(17,14).
REQ-026 WIN SHALL ignore move_valid, with move_ready = 0. restart SHALL return position to (0,0), clear won and deaths, and go to IDLE next cycle. restart SHALL be ignored in other states.
REQ-027 pos_x, pos_y and probe_x, probe_y SHALL track the current tile centre whenever not in PROBE.

Reset
REQ-028 reset SHALL override all other inputs in any state, including mid-move.
REQ-029 After reset: state IDLE, tile (0,0), pos and probe = (16,15), move_ready = 1, won = 0, deaths = 0, all pulses 0.

Structure
REQ-030 The shared package player_pkg SHALL hold: tile width/height, grid size, direction enum, state enum, start tile, finish tile (17,13), and the teleport pair table.
REQ-031 One sub-module, tile_center, SHALL convert (col,row) to centre pixel; it is instanced for the probe and position outputs.
REQ-032 The map block SHALL be instanced alongside, not inside, player_ctrl.

Verification
REQ-033 Reset, then move down with the real map: probe (16,45) in A+1; tile (0,1) and move_done in A+2; bumped = 0.
REQ-034 Reset, then move right: probe (48,15) hits a wall -> tile stays (0,0), bumped and move_done in A+2.
REQ-035 Reset, then move up: off-grid -> bumped and move_done in A+1; probe_y never leaves 15.
REQ-036 Walk down to (0,7) (lava at 16,225) -> died pulse; tile (0,0); deaths = 1.
REQ-037 Stub map asserting teleport_pink at (240,165): from (7,4), move down -> tile (7,5) in A+2, tile (13,1) with teleported and move_done in A+3.
REQ-038 Stub asserting finish_line: won = 1 and moves ignored; restart -> tile (0,0), won = 0, deaths = 0. reset during PROBE -> the REQ-029 state next cycle.
